// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port, two read ports, clear control and status.
interface reg_file_2r1w_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] din;
  logic             oen_a;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] dout_a;
  logic             dval_a;
  logic             oen_b;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] dout_b;
  logic             dval_b;
  logic             clr;
  logic             busy;
  logic             werr;

  modport master (
    output wen, waddr, din, oen_a, raddr_a, oen_b, raddr_b, clr,
    input  dout_a, dval_a, dout_b, dval_b, busy, werr
  );

  modport slave (
    input  wen, waddr, din, oen_a, raddr_a, oen_b, raddr_b, clr,
    output dout_a, dval_a, dout_b, dval_b, busy, werr
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised register file with one synchronous write port, two registered read ports,
// optional write-to-read bypass and a background clear sequencer.
module reg_file_2r1w #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter bit          BYPASS = 1'b1
) (
  input logic            CLK,
  input logic            RST_N,
  reg_file_2r1w_if.slave bus
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   DepthExt = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic             dval_a_q, dval_a_d, dval_b_q, dval_b_d;
  logic             werr_q, werr_d;
  logic             wr_ok;
  logic             waddr_ok, raddr_a_ok, raddr_b_ok;

  always_comb begin
    waddr_ok   = {1'b0, bus.waddr} < DepthExt;
    raddr_a_ok = {1'b0, bus.raddr_a} < DepthExt;
    raddr_b_ok = {1'b0, bus.raddr_b} < DepthExt;
    // A clear request in the same cycle wins over the write.
    wr_ok      = bus.wen && waddr_ok && (state_q == StIdle) && !bus.clr;
    werr_d     = bus.wen && !wr_ok;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout_a_d = dout_a_q;
    dval_a_d = dval_a_q;
    if (bus.oen_a) begin
      if (!raddr_a_ok) begin
        dout_a_d = '0;
        dval_a_d = 1'b0;
      end else if (BYPASS && wr_ok && (bus.waddr == bus.raddr_a)) begin
        dout_a_d = bus.din;
        dval_a_d = 1'b1;
      end else begin
        dout_a_d = regs_q[bus.raddr_a];
        dval_a_d = written_q[bus.raddr_a];
      end
    end
  end

  always_comb begin
    dout_b_d = dout_b_q;
    dval_b_d = dval_b_q;
    if (bus.oen_b) begin
      if (!raddr_b_ok) begin
        dout_b_d = '0;
        dval_b_d = 1'b0;
      end else if (BYPASS && wr_ok && (bus.waddr == bus.raddr_b)) begin
        dout_b_d = bus.din;
        dval_b_d = 1'b1;
      end else begin
        dout_b_d = regs_q[bus.raddr_b];
        dval_b_d = written_q[bus.raddr_b];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      regs_q    <= '{default: '0};
      written_q <= '0;
      dout_a_q  <= '0;
      dval_a_q  <= 1'b0;
      dout_b_q  <= '0;
      dval_b_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dout_a_q <= dout_a_d;
      dval_a_q <= dval_a_d;
      dout_b_q <= dout_b_d;
      dval_b_q <= dval_b_d;
      werr_q   <= werr_d;
      if (wr_ok) begin
        regs_q[bus.waddr]    <= bus.din;
        written_q[bus.waddr] <= 1'b1;
      end
      // Writes are never accepted while clearing, so the two updates cannot collide.
      if (state_q == StClear) begin
        regs_q[idx_q]    <= '0;
        written_q[idx_q] <= 1'b0;
      end
    end
  end

  assign bus.dout_a = dout_a_q;
  assign bus.dval_a = dval_a_q;
  assign bus.dout_b = dout_b_q;
  assign bus.dval_b = dval_b_q;
  assign bus.busy   = (state_q == StClear);
  assign bus.werr   = werr_q;
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised successor to the single-port 8x8 register file. It provides one synchronous write port and two independent registered read ports, with configurable width, depth and write-to-read bypass. A per-entry written flag and a background clear sequencer (IDLE/CLEAR state machine) let software wipe the array without a reset. The block sits on the datapath bus and serves two concurrent readers, such as operand fetch.

Parameters:
WIDTH, 8, data width in bits (1..64)
DEPTH, 8, number of entries (2..256; need not be a power of two)
AW, $clog2(DEPTH), address width (derived; not overridden)
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to DOUT; 0 = the old value is returned

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST_N  in  1  synchronous reset, active-low
WEN  in  1  write enable
WADDR  in  AW  write address
DIN  in  WIDTH  write data
OEN_A  in  1  read enable, port A
RADDR_A  in  AW  read address, port A
DOUT_A  out  WIDTH  registered read data, port A
DVAL_A  out  1  DOUT_A holds data from a written entry
OEN_B / RADDR_B / DOUT_B / DVAL_B  as for port A
CLR  in  1  start background clear (pulse)
BUSY  out  1  clear sequencer active
WERR  out  1  one-cycle pulse: the write in the previous cycle was dropped

Behaviour:
- Reset: sampled at the CLK rise while RST_N=0. Clears all entries to 0 and all written flags to 0. Sets DOUT_A/B=0, DVAL_A/B=0, BUSY=0, WERR=0, state=IDLE. All inputs are ignored during the reset cycle, including WEN, CLR and OEN.
- Write: if WEN=1, WADDR<DEPTH and state=IDLE at a rising edge, then REGS[WADDR]<=DIN and written[WADDR]<=1.
- Dropped write: if WEN=1 and either WADDR>=DEPTH or state=CLEAR, no storage changes. WERR=1 for exactly the next cycle; otherwise WERR=0.
- Read latency: 1 cycle, independent per port.
  - If OEN_x=1 at a rising edge, then DOUT_x<=REGS[RADDR_x] and DVAL_x<=written[RADDR_x].
  - If OEN_x=0, DOUT_x and DVAL_x hold their previous values.
  - If RADDR_x>=DEPTH with OEN_x=1: DOUT_x<=0, DVAL_x<=0.
- Same-address collision (accepted write to an address a port is reading in the same cycle):
  - BYPASS=1: DOUT_x<=DIN, DVAL_x<=1.
  - BYPASS=0: DOUT_x<=old REGS value, DVAL_x<=old flag.
  - Both ports may read the same address; each gets an identical result.
- Clear FSM:
  - IDLE: CLR=1 moves to CLEAR, loads idx=0 and sets BUSY=1 from the next cycle. CLR has priority over a write in the same cycle; that write is dropped and WERR pulses.
  - CLEAR: each cycle sets REGS[idx]<=0 and written[idx]<=0, then idx++. After idx=DEPTH-1 is cleared, the FSM returns to IDLE; BUSY=0 in the cycle after the last clear.
  - Total BUSY high time is exactly DEPTH cycles. CLR while in CLEAR is ignored (no restart).
  - Reads during CLEAR are permitted and return current array contents. Already-cleared entries give 0/DVAL=0. An entry cleared in the same edge as it is read returns its pre-clear value; bypass is not applied from the clear.
- Reset mid-clear aborts to IDLE with the full reset state.
- Width rules: no arithmetic other than idx, which is AW bits wide and wraps at DEPTH-1 to end the sweep. DIN is stored unmodified.

Test Plan:
- Reset sweep: with RST_N=0 for 2 cycles, then read all 8 addresses on A -> DOUT_A=0x00, DVAL_A=0 for every address, and BUSY=0, WERR=0.
- Fill and dual read: write 0x11*i to addresses 0..7 (0x00..0x77), then read A ascending 0..7 while B reads descending 7..0 -> each port returns the matching value one cycle after OEN, with DVAL=1.
- Bypass: preload addr 3=0x5A. In one cycle WEN=1, WADDR=3, DIN=0xC3 with OEN_A=1, RADDR_A=3 -> DOUT_A=0xC3 when BYPASS=1, or 0x5A when BYPASS=0. A read of addr 3 in the next cycle returns 0xC3 in both builds.
- Out-of-range: with DEPTH=6, write WADDR=7, DIN=0xEE -> WERR=1 for one cycle and no entry changes. A read of RADDR_B=6 -> DOUT_B=0, DVAL_B=0.
- Background clear: fill with 0xFF and pulse CLR -> BUSY=1 for exactly 8 cycles. A write issued in the 3rd busy cycle is dropped (WERR pulse). All entries then read 0 with DVAL=0. A second CLR mid-sweep does not extend BUSY.
- Reset mid-clear: assert RST_N=0 in the 4th busy cycle -> BUSY=0, all DOUT/DVAL=0 the next cycle. A write to addr 0 with 0x12 then reads back 0x12, DVAL=1.
